// File: rtl/mm_pkg.sv
// Shared types for the 4x4 product readout path: slot index, FSM states,
// read count and the upper-triangle slot table.
package mm_pkg;

    localparam int DATA_W_DEF = 16;

`ifdef SYM_SKIP_EN
    localparam int NUM_READS = 10;
`else
    localparam int NUM_READS = 16;
`endif

    typedef logic [3:0] slot_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // n-th slot of the upper triangle (row <= col), row-major
    function automatic slot_t sym_slot(input slot_t n);
        slot_t k;
        case (n)
            4'd0:    k = 4'd0;
            4'd1:    k = 4'd1;
            4'd2:    k = 4'd2;
            4'd3:    k = 4'd3;
            4'd4:    k = 4'd5;
            4'd5:    k = 4'd6;
            4'd6:    k = 4'd7;
            4'd7:    k = 4'd10;
            4'd8:    k = 4'd11;
            default: k = 4'd15;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// First-word-fall-through FIFO for captured results, with an occupancy
// count so the issuer can reserve space before reading.
module readout_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          full;
    logic          pop_ok;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            assert (!(push_i && full));
            if (push_i) begin
                wr_q <= nxt(wr_q);
            end
            if (pop_ok) begin
                rd_q <= nxt(rd_q);
            end
            if (push_i && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_i && pop_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/result_readout_seq.sv
// Walks the 4x4 product output register and streams tagged results.
// Define SYM_SKIP_EN to read only the upper-triangle slots.
module result_readout_seq
    import mm_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_out_sel,
    output logic              output_rdy,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic [3:0]        m_idx,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int    CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int    FW       = DATA_W + 5;
    localparam slot_t LAST_PTR = slot_t'(NUM_READS - 1);

    state_t     state_q, state_d;
    slot_t      ptr_q, ptr_d;
    slot_t      sel_q, sel_d;
    logic       rd_q, rd_d;
    logic       lst_q, lst_d;
    logic       done_q, done_d;
    logic       cap_q;
    slot_t      cap_idx_q;
    logic       cap_lst_q;

    slot_t      next_slot;
    logic       can_issue;
    logic       pop;
    logic       fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic [FW-1:0]    head;

`ifdef SYM_SKIP_EN
    assign next_slot = sym_slot(ptr_q);
`else
    assign next_slot = ptr_q;
`endif

    // Reserve room for reads still travelling through the output register
    assign can_issue = (int'(fifo_cnt) + int'(rd_q) + int'(cap_q))
                       < FIFO_DEPTH;

    assign m_valid     = !fifo_empty;
    assign pop         = m_valid && m_ready;
    assign m_data      = head[FW-1:5];
    assign m_idx       = head[4:1];
    assign m_last      = head[0];
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign output_rdy  = rd_q;
    assign reg_out_sel = sel_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        rd_d    = 1'b0;
        lst_d   = lst_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    ptr_d   = '0;
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    rd_d  = 1'b1;
                    sel_d = next_slot;
                    lst_d = (ptr_q == LAST_PTR);
                    if (ptr_q == LAST_PTR) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            rd_q      <= 1'b0;
            lst_q     <= 1'b0;
            done_q    <= 1'b0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            cap_lst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            lst_q     <= lst_d;
            done_q    <= done_d;
            cap_q     <= rd_q;
            cap_idx_q <= sel_q;
            cap_lst_q <= lst_q;
        end
    end

    readout_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aclr    (aclr),
        .push_i  (cap_q),
        .wdata_i ({rd_data, cap_idx_q, cap_lst_q}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_result_readout_seq.sv
// Directed bench for result_readout_seq with a queue-based stream model.
module tb_result_readout_seq;

    localparam int DW = 16;
    localparam int FD = 2;
`ifdef SYM_SKIP_EN
    localparam int NB = 10;
`else
    localparam int NB = 16;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  i;
        logic        l;
    } beat_t;

    logic          clk = 1'b0;
    logic          aclr, start, m_ready;
    logic          busy, done, output_rdy, m_valid, m_last;
    logic [3:0]    reg_out_sel, m_idx;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_data;
    logic [DW-1:0] mem [16];

    int    vectors = 0;
    int    fails = 0;
    bit    mon_en = 1'b0;
    bit    m_busy = 1'b0;
    bit    exp_done = 1'b0;
    int    issued = 0;
    int    popped = 0;
    int    issued_total = 0;
    int    beats_total = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    // Output register: dout shows the selected slot the cycle after a strobe
    always @(posedge clk) rd_data <= output_rdy ? mem[reg_out_sel] : '0;

    result_readout_seq #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .reg_out_sel (reg_out_sel),
        .output_rdy  (output_rdy),
        .rd_data     (rd_data),
        .m_data      (m_data),
        .m_idx       (m_idx),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    function automatic bit in_stream(input int k);
`ifdef SYM_SKIP_EN
        return (k / 4) <= (k % 4);
`else
        return k >= 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit    hs_last;
            beat_t b;
            hs_last = 1'b0;
            vectors++;
            if (done !== exp_done) begin
                fails++;
                $display("FAIL done @%0t: got %b want %b",
                         $time, done, exp_done);
            end
            vectors++;
            if (busy !== m_busy) begin
                fails++;
                $display("FAIL busy @%0t: got %b want %b",
                         $time, busy, m_busy);
            end
            if (m_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat @%0t: got idx %0d data %h want none",
                             $time, m_idx, m_data);
                end else begin
                    b = exp_q[0];
                    if (m_data !== b.d || m_idx !== b.i || m_last !== b.l) begin
                        fails++;
                        $display("FAIL beat @%0t: got %h/%0d/%b want %h/%0d/%b",
                                 $time, m_data, m_idx, m_last, b.d, b.i, b.l);
                    end
                    if (m_ready) begin
                        hs_last = b.l;
                        void'(exp_q.pop_front());
                        popped++;
                        beats_total++;
                    end
                end
            end
            if (output_rdy === 1'b1) begin
                issued++;
                issued_total++;
                vectors++;
                if (issued - popped > FD) begin
                    fails++;
                    $display("FAIL occupancy @%0t: got %0d outstanding want <= %0d",
                             $time, issued - popped, FD);
                end
            end
            if (aclr) begin
                m_busy   = 1'b0;
                exp_done = 1'b0;
                exp_q.delete();
                issued   = 0;
                popped   = 0;
            end else begin
                exp_done = hs_last;
                if (hs_last) begin
                    m_busy = 1'b0;
                end else if (start && !m_busy) begin
                    m_busy = 1'b1;
                    for (int k = 0; k < 16; k++) begin
                        if (in_stream(k)) begin
                            b.d = mem[k];
                            b.i = 4'(k);
                            b.l = (k == 15);
                            exp_q.push_back(b);
                        end
                    end
                end
            end
        end
    end

    // mode 0: ready high; 1: ready 1,0,0,1; 2: ready low for 20 cycles
    task automatic run_stream(input int mode, input int restart_at,
                              input bit pin, output int nb, output int ns);
        int b0, s0, lat;
        bit got;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        b0 = beats_total;
        s0 = issued_total;
        m_ready = (mode != 2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        got = 1'b0;
        for (int c = 0; c < 800 && !got; c++) begin
            if (mode == 1) m_ready = pat[c % 4];
            else if (mode == 2) m_ready = (c >= 20);
            else m_ready = 1'b1;
            if (mode == 2 && c == 20) begin
                chk("t3_reads_held", issued_total - s0, FD);
            end
            start = (c == restart_at);
            @(posedge clk);
            #1;
            if (pin && lat < 0 && m_valid === 1'b1) begin
                lat = c + 1;
                chk("t1_latency", lat, 3);
                chk("t1_first_data", m_data, 32'h0100);
                chk("t1_first_idx", m_idx, 0);
            end
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            vectors++;
            fails++;
            $display("FAIL done_timeout: got no done want done within 800 cycles");
        end
        nb = beats_total - b0;
        ns = issued_total - s0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdy"}, output_rdy, 0);
        chk({tag, "_sel"}, reg_out_sel, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_idx"}, m_idx, 0);
        chk({tag, "_last"}, m_last, 0);
    endtask

    initial begin
        int  nb, ns;
        bit  got;
        aclr = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 16'h0100 + 16'(k);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        aclr = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        run_stream(0, -1, 1'b1, nb, ns);
        chk("t1_beats", nb, NB);
        chk("t1_strobes", ns, NB);

        run_stream(1, -1, 1'b0, nb, ns);
        chk("t2_beats", nb, NB);

        run_stream(2, -1, 1'b0, nb, ns);
        chk("t3_beats", nb, NB);

        for (int k = 0; k < 16; k++) mem[k] = 16'hA000 + 16'(k * 3);
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            if (output_rdy === 1'b1 && reg_out_sel == 4'd7) got = 1'b1;
        end
        chk("t4_idx7_seen", got, 1);
        aclr = 1'b1;
        @(posedge clk);
        #1;
        aclr = 1'b0;
        chk_reset_outs("t4");
        repeat (3) @(posedge clk);
        #1;
        run_stream(0, -1, 1'b0, nb, ns);
        chk("t4_beats", nb, NB);

        for (int k = 0; k < 16; k++) mem[k] = 16'h0100 + 16'(k);
        run_stream(0, 5, 1'b0, nb, ns);
        chk("t5_beats", nb, NB);
        aclr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        aclr = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t5_no_busy", busy, 0);
            chk("t5_no_valid", m_valid, 0);
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
